// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Counter width bounds the latency to 1..15 cycles.
package dmem_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } stateT;

  localparam int LAT_DEFAULT = 3;
  localparam int CNT_W       = 4;
  localparam int TAG_W       = 5;

endpackage

// File: rtl/dmem_lat_counter.sv
// Reusable latency down-counter with load, decrement and zero flag.
// Decrement stops at zero.
module dmem_lat_counter
  import dmem_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             CLR,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // load has priority over decrement
  always_ff @(posedge CLK) begin
    if (CLR)
      cnt <= '0;
    else if (load)
      cnt <= loadVal;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage sequencer for the multi-cycle data memory, one access in flight.
// Define DMEM_CTRL_PERF_EN to build the saturating perf counters.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = LAT_DEFAULT
)(
  input  logic             CLK,
  input  logic             CLR,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             stall,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             pend_valid,
  output logic [TAG_W-1:0] pend_tag,
  output logic [31:0]      perf_loads,
  output logic [31:0]      perf_stores,
  output logic [31:0]      perf_stalls
);

  stateT            state;
  logic             latWe;
  logic [WIDTH-1:0] latAddr;
  logic [WIDTH-1:0] latWdata;
  logic [TAG_W-1:0] latTag;
  logic [CNT_W-1:0] cnt;
  logic             cntZero;
  logic             accept;
  logic             done;

  assign accept = (state == IDLE) & req_valid;
  assign done   = (state == WAIT) & cntZero;

  dmem_lat_counter uCnt (
    .CLK     (CLK),
    .CLR     (CLR),
    .load    (accept),
    .loadVal (CNT_W'(LAT - 1)),
    .dec     (state == WAIT),
    .cnt     (cnt),
    .zero    (cntZero)
  );

  // request latching, state sequencing and registered load response
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      latWe     <= 1'b0;
      latAddr   <= '0;
      latWdata  <= '0;
      latTag    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else begin
      rsp_valid <= done & ~latWe;
      if (done & ~latWe) begin
        rsp_data <= mem_rdata;
        rsp_tag  <= latTag;
      end
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            latWe    <= req_we;
            latAddr  <= req_addr;
            latWdata <= req_wdata;
            latTag   <= req_tag;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cntZero)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a reset landing on the completion cycle must not commit the store
  assign req_ready  = (state == IDLE);
  assign stall      = req_valid & ~req_ready;
  assign mem_we     = done & latWe & ~CLR;
  assign mem_addr   = req_ready ? req_addr : latAddr;
  assign mem_wdata  = latWdata;
  assign pend_valid = (state == WAIT) & ~latWe;
  assign pend_tag   = latTag;

`ifdef DMEM_CTRL_PERF_EN
  logic [31:0] perfLd;
  logic [31:0] perfSt;
  logic [31:0] perfSl;

  // saturating event counters
  always_ff @(posedge CLK) begin
    if (CLR) begin
      perfLd <= '0;
      perfSt <= '0;
      perfSl <= '0;
    end else begin
      if (accept && !req_we && perfLd != '1)
        perfLd <= perfLd + 1'b1;
      if (accept && req_we && perfSt != '1)
        perfSt <= perfSt + 1'b1;
      if (stall && perfSl != '1)
        perfSl <= perfSl + 1'b1;
    end
  end

  assign perf_loads  = perfLd;
  assign perf_stores = perfSt;
  assign perf_stalls = perfSl;
`else
  assign perf_loads  = '0;
  assign perf_stores = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed table, LAT=1 instance,
// and random traffic against a cycle-number reference model.
module tb_dmem_access_ctrl;

  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [4:0]  req_tag;
  logic        req_ready, stall, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        rsp_valid, pend_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag, pend_tag;
  logic [31:0] perf_loads, perf_stores, perf_stalls;

  logic        d1_clr, d1_valid, d1_we;
  logic [31:0] d1_addr, d1_wdata, d1_rdata;
  logic [4:0]  d1_tag;
  logic        d1_ready, d1_stall, d1_mwe;
  logic [31:0] d1_maddr, d1_mwdata;
  logic        d1_rspv, d1_pendv;
  logic [31:0] d1_rspd;
  logic [4:0]  d1_rspt, d1_pendt;
  logic [31:0] d1_pl, d1_ps, d1_pst;

  always #5 CLK = ~CLK;

  dmem_access_ctrl #(.WIDTH(32), .LAT(LAT)) dut (
    .CLK(CLK), .CLR(CLR),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag), .req_ready(req_ready),
    .stall(stall), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .pend_valid(pend_valid), .pend_tag(pend_tag),
    .perf_loads(perf_loads), .perf_stores(perf_stores),
    .perf_stalls(perf_stalls)
  );

  dmem_access_ctrl #(.WIDTH(32), .LAT(1)) dut1 (
    .CLK(CLK), .CLR(d1_clr),
    .req_valid(d1_valid), .req_we(d1_we),
    .req_addr(d1_addr), .req_wdata(d1_wdata),
    .req_tag(d1_tag), .req_ready(d1_ready),
    .stall(d1_stall), .mem_we(d1_mwe),
    .mem_addr(d1_maddr), .mem_wdata(d1_mwdata),
    .mem_rdata(d1_rdata), .rsp_valid(d1_rspv),
    .rsp_data(d1_rspd), .rsp_tag(d1_rspt),
    .pend_valid(d1_pendv), .pend_tag(d1_pendt),
    .perf_loads(d1_pl), .perf_stores(d1_ps),
    .perf_stalls(d1_pst)
  );

  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  bit          mBusy = 0;
  int          mDone = 0;
  bit          mWe = 0;
  logic [31:0] mAddr = '0, mData = '0;
  logic [4:0]  mTag = '0;
  bit          mRspV = 0;
  logic [31:0] mRspD = '0;
  logic [4:0]  mRspT = '0;
  int unsigned mLd = 0, mSt = 0, mSl = 0;

  task automatic modelStep();
    bit fin;
    chk("ready", req_ready, !mBusy);
    chk("stall", stall, req_valid && mBusy);
    chk("mem_we", mem_we, mBusy && cyc == mDone && mWe && !CLR);
    chk("mem_addr", mem_addr, mBusy ? mAddr : req_addr);
    if (mBusy) chk("mem_wdata", mem_wdata, mData);
    chk("pend_valid", pend_valid, mBusy && !mWe);
    if (mBusy) chk("pend_tag", pend_tag, mTag);
    chk("rsp_valid", rsp_valid, mRspV);
    chk("rsp_data", rsp_data, mRspD);
    chk("rsp_tag", rsp_tag, mRspT);
`ifdef DMEM_CTRL_PERF_EN
    chk("perf_loads", perf_loads, mLd);
    chk("perf_stores", perf_stores, mSt);
    chk("perf_stalls", perf_stalls, mSl);
`else
    chk("perf_loads", perf_loads, 0);
    chk("perf_stores", perf_stores, 0);
    chk("perf_stalls", perf_stalls, 0);
`endif
    if (CLR) begin
      mBusy = 0; mWe = 0; mAddr = '0; mData = '0; mTag = '0;
      mRspV = 0; mRspD = '0; mRspT = '0;
      mLd = 0; mSt = 0; mSl = 0;
    end else begin
      fin = mBusy && cyc == mDone;
      mRspV = fin && !mWe;
      if (mRspV) begin
        mRspD = mem_rdata;
        mRspT = mTag;
      end
      if (req_valid && mBusy) mSl++;
      if (!mBusy && req_valid) begin
        if (req_we) mSt++; else mLd++;
        mBusy = 1;
        mDone = cyc + LAT;
        mWe = req_we; mAddr = req_addr;
        mData = req_wdata; mTag = req_tag;
      end else if (fin) begin
        mBusy = 0;
      end
    end
    cyc++;
  endtask

  task automatic drive(bit c, bit v, bit w, logic [31:0] a,
                       logic [31:0] d, logic [4:0] t, logic [31:0] r);
    CLR = c; req_valid = v; req_we = w; req_addr = a;
    req_wdata = d; req_tag = t; mem_rdata = r;
  endtask

  task automatic endCycle();
    modelStep();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    bit clr, v, we;
    logic [31:0] addr, wd;
    logic [4:0] tag;
    logic [31:0] rd;
    bit eRdy, eStall, eWe, ePend, eRspV;
    logic [31:0] eAddr, eRspD;
    logic [4:0] eRspT;
  } vecT;

  vecT tbl[23];

  task automatic setv(int i, bit c, bit v, bit w, logic [31:0] a,
                      logic [31:0] d, logic [4:0] t, logic [31:0] r,
                      bit rdy, bit st, bit mw, logic [31:0] ea,
                      bit pd, bit rv, logic [31:0] rdat, logic [4:0] rt);
    tbl[i] = '{c, v, w, a, d, t, r, rdy, st, mw, pd, rv, ea, rdat, rt};
  endtask

  initial begin
    //   i  clr v we addr   wdata  tag rdata        rdy st we eaddr  pd rv rspd         rt
    setv(0, 0, 1, 0, 32'h10, 0, 8, 0,             1, 0, 0, 32'h10, 0, 0, 0,            0);
    setv(1, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 32'h10, 1, 0, 0,            0);
    setv(2, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 32'h10, 1, 0, 0,            0);
    setv(3, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF,       0, 0, 0, 32'h10, 1, 0, 0,            0);
    setv(4, 0, 0, 0, 0, 0, 0, 0,                  1, 0, 0, 0,      0, 1, 32'hDEADBEEF, 8);
    setv(5, 0, 1, 1, 32'h20, 32'h12345678, 0, 0,  1, 0, 0, 32'h20, 0, 0, 32'hDEADBEEF, 8);
    setv(6, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 32'h20, 0, 0, 32'hDEADBEEF, 8);
    setv(7, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 32'h20, 0, 0, 32'hDEADBEEF, 8);
    setv(8, 0, 0, 0, 0, 0, 0, 32'h5555,           0, 0, 1, 32'h20, 0, 0, 32'hDEADBEEF, 8);
    setv(9, 0, 1, 1, 32'h30, 32'hAA, 0, 0,        1, 0, 0, 32'h30, 0, 0, 32'hDEADBEEF, 8);
    setv(10, 0, 1, 0, 32'h40, 0, 3, 0,            0, 1, 0, 32'h30, 0, 0, 32'hDEADBEEF, 8);
    setv(11, 0, 1, 0, 32'h40, 0, 3, 0,            0, 1, 0, 32'h30, 0, 0, 32'hDEADBEEF, 8);
    setv(12, 0, 1, 0, 32'h40, 0, 3, 0,            0, 1, 1, 32'h30, 0, 0, 32'hDEADBEEF, 8);
    setv(13, 0, 1, 0, 32'h40, 0, 3, 0,            1, 0, 0, 32'h40, 0, 0, 32'hDEADBEEF, 8);
    setv(14, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 32'h40, 1, 0, 32'hDEADBEEF, 8);
    setv(15, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 32'h40, 1, 0, 32'hDEADBEEF, 8);
    setv(16, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D,      0, 0, 0, 32'h40, 1, 0, 32'hDEADBEEF, 8);
    setv(17, 0, 0, 0, 0, 0, 0, 0,                 1, 0, 0, 0,      0, 1, 32'hCAFEF00D, 3);
    setv(18, 0, 1, 1, 32'h50, 32'h55, 0, 0,       1, 0, 0, 32'h50, 0, 0, 32'hCAFEF00D, 3);
    setv(19, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 32'h50, 0, 0, 32'hCAFEF00D, 3);
    setv(20, 1, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 32'h50, 0, 0, 32'hCAFEF00D, 3);
    setv(21, 0, 0, 0, 0, 0, 0, 0,                 1, 0, 0, 0,      0, 0, 0,            0);
    setv(22, 0, 0, 0, 0, 0, 0, 0,                 1, 0, 0, 0,      0, 0, 0,            0);

    drive(1, 0, 0, 0, 0, 0, 0);
    d1_clr = 1; d1_valid = 0; d1_we = 0; d1_addr = '0;
    d1_wdata = '0; d1_tag = '0; d1_rdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    d1_clr = 0;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].clr, tbl[i].v, tbl[i].we, tbl[i].addr,
            tbl[i].wd, tbl[i].tag, tbl[i].rd);
      #4;
      chk($sformatf("t%0d.ready", i), req_ready, tbl[i].eRdy);
      chk($sformatf("t%0d.stall", i), stall, tbl[i].eStall);
      chk($sformatf("t%0d.mem_we", i), mem_we, tbl[i].eWe);
      chk($sformatf("t%0d.mem_addr", i), mem_addr, tbl[i].eAddr);
      chk($sformatf("t%0d.pend", i), pend_valid, tbl[i].ePend);
      chk($sformatf("t%0d.rsp_valid", i), rsp_valid, tbl[i].eRspV);
      chk($sformatf("t%0d.rsp_data", i), rsp_data, tbl[i].eRspD);
      chk($sformatf("t%0d.rsp_tag", i), rsp_tag, tbl[i].eRspT);
      endCycle();
    end

    // LAT=1 instance: load then store
    drive(0, 0, 0, 0, 0, 0, 0);
    d1_valid = 1; d1_we = 0; d1_addr = 32'h100; d1_tag = 9;
    #4;
    chk("l1.accept_ready", d1_ready, 1);
    endCycle();
    d1_valid = 0; d1_addr = 0; d1_rdata = 32'h0BADF00D;
    #4;
    chk("l1.wait_ready", d1_ready, 0);
    chk("l1.pend", d1_pendv, 1);
    chk("l1.pend_tag", d1_pendt, 9);
    chk("l1.maddr", d1_maddr, 32'h100);
    chk("l1.rspv_early", d1_rspv, 0);
    endCycle();
    d1_valid = 1; d1_we = 1; d1_addr = 32'h200;
    d1_wdata = 32'h77; d1_rdata = 0;
    #4;
    chk("l1.rspv", d1_rspv, 1);
    chk("l1.rspd", d1_rspd, 32'h0BADF00D);
    chk("l1.rspt", d1_rspt, 9);
    chk("l1.ready2", d1_ready, 1);
    chk("l1.no_we_idle", d1_mwe, 0);
    endCycle();
    d1_valid = 0; d1_addr = 0;
    #4;
    chk("l1.st_we", d1_mwe, 1);
    chk("l1.st_addr", d1_maddr, 32'h200);
    chk("l1.st_wdata", d1_mwdata, 32'h77);
    chk("l1.st_norsp", d1_rspv, 0);
    endCycle();
    #4;
    chk("l1.st_we_off", d1_mwe, 0);
    chk("l1.st_ready", d1_ready, 1);
    chk("l1.st_norsp2", d1_rspv, 0);
    endCycle();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 64) == 0, $urandom % 2, $urandom % 2,
            $urandom, $urandom, 5'($urandom % 32), $urandom);
      #4;
      endCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer for the multi-cycle data memory in the M stage of the 5-stage pipeline. It accepts one load or store request at a time and holds address/data stable for the full memory latency. It returns load data tagged with the destination register, and drives the stall and pending-load information the hazard unit consumes. Only one access is ever outstanding.

## Interface
Parameters:
- WIDTH, 32, data/address width
- LAT, 3, data memory access latency in cycles (legal range 1..15)

Ports:
- CLK  in  1  clock; all state changes on posedge
- CLR  in  1  reset, synchronous, active-high
- req_valid  in  1  M-stage access request (load or store)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data
- req_tag  in  5  load destination register
- req_ready  out  1  request accepted this cycle
- stall  out  1  req_valid & ~req_ready; holds F/D/E/M
- mem_we  out  1  memory write strobe
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data
- rsp_valid  out  1  load result valid (1-cycle pulse)
- rsp_data  out  WIDTH  load result
- rsp_tag  out  5  load destination register
- pend_valid  out  1  a load is in flight
- pend_tag  out  5  register of the in-flight load
- perf_loads, perf_stores, perf_stalls  out  32 each  counters (see Configuration)

## Operation
- FSM states: IDLE, WAIT.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch we/addr/wdata/tag, cnt <= LAT-1, go to WAIT.
- WAIT:
  - req_ready = 0.
  - mem_addr/mem_wdata driven from latches, stable throughout.
  - cnt decrements each cycle. The cycle with cnt==0 is the completion cycle.
  - Completion cycle, store: mem_we = 1 for exactly that cycle.
  - Completion cycle, load: mem_rdata sampled into rsp_data; rsp_tag <= latched tag; rsp_valid <= 1.
  - After completion, go to IDLE.
- mem_we is never asserted outside the completion cycle of a store.
- mem_addr in IDLE is req_addr (passthrough), so address setup starts in the accept cycle.
- pend_valid = (state==WAIT) & ~latched_we; pend_tag = latched tag.
- Counter width: 4 bits. LAT=1 gives cnt=0 on entry, so the completion cycle is the first WAIT cycle.
- Reset mid-access: the in-flight request is dropped. No mem_we and no rsp_valid result from it.

## Timing
- Accept at edge k → WAIT occupies cycles k+1..k+LAT → rsp_valid high in cycle k+LAT+1.
- The earliest next accept is in cycle k+LAT+1: IDLE with req_ready = 1. Back-to-back throughput is one access per LAT+1 cycles.
- rsp_valid is registered, one cycle wide, and never asserted for stores.
- stall is combinational from req_valid and state.
- Reset values (CLR=1 at an edge): state IDLE, cnt 0, rsp_valid 0, rsp_data 0, rsp_tag 0, latches 0, all perf counters 0.
- Outputs after reset: mem_we 0, pend_valid 0.
- Simultaneous rsp_valid and a new accept are legal; they are independent.

## Configuration
- DMEM_CTRL_PERF_EN defined:
  - perf_loads increments on each load accept.
  - perf_stores increments on each store accept.
  - perf_stalls increments on each cycle with stall=1.
  - All counters are 32-bit, saturate at 0xFFFFFFFF, and clear on CLR.
- DMEM_CTRL_PERF_EN undefined: the perf ports remain but are tied to 0, and no counter registers exist.

## Structure
- Shared package dmem_ctrl_pkg:
  - state enum (IDLE, WAIT)
  - LAT_DEFAULT = 3
  - counter width constant CNT_W = 4
  - TAG_W = 5
- One sub-module: dmem_lat_counter. It provides load/decrement/zero-flag for cnt and is reused by any later multi-cycle unit.

## Test plan
All scenarios use LAT=3.
- Load, single: load addr 0x10, tag 8, mem returns 0xDEADBEEF → req_ready only at accept; rsp_valid at cycle +4 with rsp_data 0xDEADBEEF, rsp_tag 8; pend_valid high for 3 cycles.
- Store: addr 0x20, data 0x12345678 → mem_we high for exactly 1 cycle (third WAIT cycle); mem_addr = 0x20 stable for all 3 WAIT cycles; no rsp_valid.
- Back-to-back: store then load held on req_valid → stall=1 for 3 cycles; load accepted at cycle +4; its rsp_valid at cycle +8.
- Reset mid-access: CLR at second WAIT cycle of a store → mem_we never pulses; state IDLE; req_ready=1 next cycle.
- LAT=1 rebuild: load → rsp_valid 2 cycles after accept; mem_we timing for a store is the first WAIT cycle.
- DMEM_CTRL_PERF_EN: 2 loads, 1 store, 6 stall cycles → perf_loads=2, perf_stores=1, perf_stalls=6. Without the macro, all perf outputs read 0.
